// File: rtl/dram_mux_pkg.sv
// -----------------------------------------------------------------------------
// dram_mux_pkg
// Shared definitions for the multiplexed-address DRAM model:
//   - dram_state_t : access state encoding, also driven out on o_STATE
//   - compose_index: builds the flat array index from the latched row/column
// -----------------------------------------------------------------------------
package dram_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ROW_OPEN   = 2'd1,
        ST_COL_ACTIVE = 2'd2,
        ST_REFRESH    = 2'd3
    } dram_state_t;

    // COL_MAJOR=1 places the column in the upper index bits ({col,row}),
    // otherwise the row goes on top ({row,col}). Callers truncate the result.
    function automatic logic [31:0] compose_index(
        input logic [31:0] row,
        input logic [31:0] col,
        input int          row_w,
        input int          col_w,
        input logic        col_major
    );
        if (col_major) begin
            return (col << row_w) | row;
        end
        return (row << col_w) | col;
    endfunction

endpackage

// File: rtl/dram_mux_model_if.sv
// -----------------------------------------------------------------------------
// dram_mux_model_if
// Pin bundle of the multiplexed DRAM. Signal names are from the DRAM's view.
//   i_ADDR      multiplexed row/column address
//   i_DIN       write data
//   o_DOUT      registered read data
//   o_DVALID    one-cycle strobe per read result
//   i_RAS_n     row strobe, active low
//   i_CAS_n     column strobe, active low
//   i_WR_n      write enable, active low, level-sensitive
//   i_RD_n      read enable, active low, level-sensitive
//   o_STATE     current access state (dram_state_t encoding)
//   o_REF_ROW   internal CBR refresh row counter
//   o_PROTO_ERR sticky protocol violation flag
// Strobe protocol: the master owns RAS/CAS/WR/RD and the DRAM has no ready;
// a RAS or CAS fall acts on the clock edge where the pin is first seen low,
// WR_n/RD_n act on every edge they are low in COL_ACTIVE, and each accepted
// read returns exactly one o_DVALID pulse RD_LAT cycles later.
// Modports: master = timing generator side, slave = DRAM model side.
// -----------------------------------------------------------------------------
interface dram_mux_model_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8,
    parameter int ROW_W  = 8
);
    logic [ADDR_W-1:0] i_ADDR;
    logic [DATA_W-1:0] i_DIN;
    logic [DATA_W-1:0] o_DOUT;
    logic              o_DVALID;
    logic              i_RAS_n;
    logic              i_CAS_n;
    logic              i_WR_n;
    logic              i_RD_n;
    logic [1:0]        o_STATE;
    logic [ROW_W-1:0]  o_REF_ROW;
    logic              o_PROTO_ERR;

    modport master (
        output i_ADDR, i_DIN, i_RAS_n, i_CAS_n, i_WR_n, i_RD_n,
        input  o_DOUT, o_DVALID, o_STATE, o_REF_ROW, o_PROTO_ERR
    );

    modport slave (
        input  i_ADDR, i_DIN, i_RAS_n, i_CAS_n, i_WR_n, i_RD_n,
        output o_DOUT, o_DVALID, o_STATE, o_REF_ROW, o_PROTO_ERR
    );
endinterface

// File: rtl/dram_mux_rd_pipe.sv
// -----------------------------------------------------------------------------
// dram_mux_rd_pipe
// RD_LAT-deep data+valid shift register for the read return path.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears all stages)
//   i_vld, i_dat   : read issued this cycle and the data read
//   o_vld, o_dat   : result strobe and data, RD_LAT cycles after issue
// Data stages only load when their incoming valid is set, so the last stage
// (the output) holds the previous result between strobes.
// -----------------------------------------------------------------------------
module dram_mux_rd_pipe #(
    parameter int DATA_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_dat,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_dat
);
    logic [RD_LAT-1:0] r_vld;
    logic [DATA_W-1:0] r_dat [RD_LAT];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
            r_vld[0] <= i_vld;
            if (i_vld) begin
                r_dat[0] <= i_dat;
            end
        end
    end

    assign o_vld = r_vld[RD_LAT-1];
    assign o_dat = r_dat[RD_LAT-1];
endmodule

// File: rtl/dram_mux_model.sv
// -----------------------------------------------------------------------------
// dram_mux_model
// Behavioural multiplexed-address (RAS/CAS) DRAM with fast-page mode,
// CAS-before-RAS refresh, configurable read latency and a sticky
// protocol-error flag. Everything runs on the rising edge of i_MCLK.
//   i_MCLK  : master clock
//   i_RST_n : asynchronous active-low reset (array contents are kept)
//   bus     : dram_mux_model_if.slave pin bundle (address, data, strobes,
//             state, refresh row, protocol error)
// Optional build macro DRAM_MUX_ACCESS_STATS_EN adds saturating counters:
//   o_ROW_CNT  : row opens
//   o_PAGE_CNT : column accesses after the first one in a RAS cycle
//   o_REF_CNT  : CBR refreshes
// -----------------------------------------------------------------------------
module dram_mux_model
    import dram_mux_pkg::*;
#(
    parameter int    DATA_W    = 4,
    parameter int    ADDR_W    = 8,
    parameter int    ROW_W     = 8,
    parameter int    COL_W     = 6,
    parameter int    COL_LSB   = 1,
    parameter bit    COL_MAJOR = 1'b1,
    parameter int    RD_LAT    = 1,
    parameter string INIT_FILE = ""
) (
    input  logic             i_MCLK,
    input  logic             i_RST_n,
    dram_mux_model_if.slave  bus
`ifdef DRAM_MUX_ACCESS_STATS_EN
    ,
    output logic [15:0]      o_ROW_CNT,
    output logic [15:0]      o_PAGE_CNT,
    output logic [15:0]      o_REF_CNT
`endif
);
    localparam int IDX_W = ROW_W + COL_W;
    localparam int DEPTH = 1 << IDX_W;

    logic              r_prev_ras;
    logic              r_prev_cas;
    dram_state_t       r_state;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_ref_row;
    logic              r_proto_err;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ras_fall;
    logic              w_ras_rise;
    logic              w_cas_fall;
    logic              w_cas_rise;
    logic              w_wr;
    logic              w_rd;
    logic              w_access_err;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_dvalid;
    logic [DATA_W-1:0] w_dout;

    assign w_ras_fall = !bus.i_RAS_n &&  r_prev_ras;
    assign w_ras_rise =  bus.i_RAS_n && !r_prev_ras;
    assign w_cas_fall = !bus.i_CAS_n &&  r_prev_cas;
    assign w_cas_rise =  bus.i_CAS_n && !r_prev_cas;

    assign w_wr         = (r_state == ST_COL_ACTIVE) && !bus.i_WR_n;
    assign w_rd         = (r_state == ST_COL_ACTIVE) && !bus.i_RD_n;
    assign w_access_err = (!bus.i_WR_n || !bus.i_RD_n) && (r_state != ST_COL_ACTIVE);

    assign w_idx     = IDX_W'(compose_index(32'(r_row), 32'(r_col), ROW_W, COL_W, COL_MAJOR));
    assign w_rd_data = r_mem[w_idx];

    // Access state machine. RAS rise closes the cycle from any state.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_prev_ras  <= 1'b1;
            r_prev_cas  <= 1'b1;
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_ref_row   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_prev_ras <= bus.i_RAS_n;
            r_prev_cas <= bus.i_CAS_n;
            if (w_access_err) begin
                r_proto_err <= 1'b1;
            end
            if (w_ras_rise) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ras_fall) begin
                            if (r_prev_cas) begin
                                r_row   <= bus.i_ADDR[ROW_W-1:0];
                                r_state <= ST_ROW_OPEN;
                                // CAS falling on the same edge is dropped.
                                if (w_cas_fall) begin
                                    r_proto_err <= 1'b1;
                                end
                            end else begin
                                // CAS was already low: CBR refresh.
                                r_state   <= ST_REFRESH;
                                r_ref_row <= r_ref_row + 1'b1;
                            end
                        end
                    end
                    ST_ROW_OPEN: begin
                        if (w_cas_fall) begin
                            r_col   <= bus.i_ADDR[COL_LSB+COL_W-1:COL_LSB];
                            r_state <= ST_COL_ACTIVE;
                        end
                    end
                    ST_COL_ACTIVE: begin
                        if (w_cas_rise) begin
                            r_state <= ST_ROW_OPEN;
                        end
                    end
                    ST_REFRESH: begin
                        if (w_cas_fall) begin
                            r_proto_err <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Array write port; contents survive reset.
    always_ff @(posedge i_MCLK) begin
        if (w_wr) begin
            r_mem[w_idx] <= bus.i_DIN;
        end
    end

    // Read data is sampled before this edge's write lands: read-first.
    dram_mux_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .i_clk   (i_MCLK),
        .i_rst_n (i_RST_n),
        .i_vld   (w_rd),
        .i_dat   (w_rd_data),
        .o_vld   (w_dvalid),
        .o_dat   (w_dout)
    );

    assign bus.o_DOUT      = w_dout;
    assign bus.o_DVALID    = w_dvalid;
    assign bus.o_STATE     = r_state;
    assign bus.o_REF_ROW   = r_ref_row;
    assign bus.o_PROTO_ERR = r_proto_err;

`ifdef DRAM_MUX_ACCESS_STATS_EN
    logic        r_cas_seen;
    logic [15:0] r_row_cnt;
    logic [15:0] r_page_cnt;
    logic [15:0] r_ref_cnt;
    logic        w_row_open;
    logic        w_cbr;
    logic        w_col_latch;

    assign w_row_open  = (r_state == ST_IDLE) && w_ras_fall && r_prev_cas;
    assign w_cbr       = (r_state == ST_IDLE) && w_ras_fall && !r_prev_cas;
    assign w_col_latch = (r_state == ST_ROW_OPEN) && !w_ras_rise && w_cas_fall;

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_cas_seen <= 1'b0;
            r_row_cnt  <= '0;
            r_page_cnt <= '0;
            r_ref_cnt  <= '0;
        end else begin
            if (w_row_open) begin
                r_cas_seen <= 1'b0;
                if (r_row_cnt != 16'hFFFF) r_row_cnt <= r_row_cnt + 16'd1;
            end
            if (w_col_latch) begin
                r_cas_seen <= 1'b1;
                if (r_cas_seen && r_page_cnt != 16'hFFFF) r_page_cnt <= r_page_cnt + 16'd1;
            end
            if (w_cbr && r_ref_cnt != 16'hFFFF) begin
                r_ref_cnt <= r_ref_cnt + 16'd1;
            end
        end
    end

    assign o_ROW_CNT  = r_row_cnt;
    assign o_PAGE_CNT = r_page_cnt;
    assign o_REF_CNT  = r_ref_cnt;
`endif
endmodule
